// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and defaults for the RAM responder
// Contents: STACK_PAGE default, FSM state enum, address-decode kind enum.
package ram_pkg;

  localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h13;

  typedef enum logic {
    CLEAR,
    SERVE
  } state_e;

  typedef enum logic [1:0] {
    LOW,
    STACK,
    FAULT
  } dec_e;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - 2^MEM_AW x 16 simple dual-port storage with write-port mux
// Ports:
//   clk        clock
//   clr_we_i   clear write (CLEAR phase), address clr_a_i, data forced to 0
//   cm_we_i    pending-entry commit, address cm_a_i, data cm_d_i
//   ra_i       read address, sampled every edge
//   rd_o       registered read data (old data on same-edge write)
module ram_array
  import ram_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              clr_we_i,
  input  logic [MEM_AW-1:0] clr_a_i,
  input  logic              cm_we_i,
  input  logic [MEM_AW-1:0] cm_a_i,
  input  logic [15:0]       cm_d_i,
  input  logic [MEM_AW-1:0] ra_i,
  output logic [15:0]       rd_o
);

  logic [15:0]       mem [0:(1<<MEM_AW)-1];
  logic [15:0]       rd_q;
  logic              we;
  logic [MEM_AW-1:0] wa;
  logic [15:0]       wd;

  // Clear and commit never overlap: commits only exist in SERVE.
  always_comb begin
    we = 1'b0;
    wa = cm_a_i;
    wd = cm_d_i;
    if (clr_we_i) begin
      we = 1'b1;
      wa = clr_a_i;
      wd = 16'h0000;
    end else if (cm_we_i) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    rd_q <= mem[ra_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - RAM-side bus responder: decode, clear FSM, write buffer, forwarding
// Ports:
//   clk        clock
//   rst        synchronous active-low reset
//   RAMaddr    bus address
//   toRAM      write data, qualified by w
//   w          write strobe
//   fromRAM    read data for the previous cycle's address
//   ready      clear finished, accesses serviced
//   stackHit   previous address was in the stack page
//   addrFault  previous address was unmapped
module ram_responder
  import ram_pkg::*;
#(
  parameter int         MEM_AW     = 10,
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] RAMaddr,
  input  logic [15:0] toRAM,
  input  logic        w,
  output logic [15:0] fromRAM,
  output logic        ready,
  output logic        stackHit,
  output logic        addrFault
);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] cnt_q, cnt_d;
  logic              clr_we;

  dec_e              dec;
  logic [MEM_AW-1:0] idx;
  logic              serve;
  logic              accept;

  logic              pend_v_q, pend_v_d;
  logic [MEM_AW-1:0] pend_a_q;
  logic [15:0]       pend_d_q;

  logic              rvalid_q, rvalid_d;
  logic              fwd_q, fwd_d;
  logic [15:0]       fwd_data_q, fwd_data_d;
  logic              stack_q, stack_d;
  logic              fault_q, fault_d;
  logic [15:0]       rd_data;

  // Stack page maps onto the top 256 words; it wins over LOW if they overlap.
  always_comb begin
    dec = FAULT;
    idx = RAMaddr[MEM_AW-1:0];
    if (RAMaddr[15:8] == STACK_PAGE) begin
      dec = STACK;
      idx = {{(MEM_AW-8){1'b1}}, RAMaddr[7:0]};
    end else if (RAMaddr[15:MEM_AW] == '0) begin
      dec = LOW;
    end
  end

  assign serve  = (state_q == SERVE);
  assign accept = serve && w && (dec != FAULT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = SERVE;
        end
      end
      default: begin
        state_d = SERVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An unaccepted cycle empties the buffer because the old entry commits now.
  assign pend_v_d = accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_v_q <= 1'b0;
    end else begin
      pend_v_q <= pend_v_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_a_q <= idx;
      pend_d_q <= toRAM;
    end
  end

  // The array read at this edge misses both this cycle's write and the entry
  // committing at the same edge, so both are captured for forwarding here.
  always_comb begin
    rvalid_d   = serve && (dec != FAULT);
    fwd_d      = accept || (pend_v_q && (pend_a_q == idx));
    fwd_data_d = accept ? toRAM : pend_d_q;
    stack_d    = serve && (dec == STACK);
    fault_d    = serve && (dec == FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= 16'h0000;
      stack_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      rvalid_q   <= rvalid_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      stack_q    <= stack_d;
      fault_q    <= fault_d;
    end
  end

  ram_array #(
    .MEM_AW (MEM_AW)
  ) u_array (
    .clk      (clk),
    .clr_we_i (rst && clr_we),
    .clr_a_i  (cnt_q),
    .cm_we_i  (rst && pend_v_q),
    .cm_a_i   (pend_a_q),
    .cm_d_i   (pend_d_q),
    .ra_i     (idx),
    .rd_o     (rd_data)
  );

  assign fromRAM   = rvalid_q ? (fwd_q ? fwd_data_q : rd_data) : 16'h0000;
  assign ready     = serve;
  assign stackHit  = stack_q;
  assign addrFault = fault_q;

endmodule
